hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- EX-stage HI/LO producer: computes the 64-bit value and write enable that the HI/LO register consumes.
- MULT/MULTU/MTHI/MTLO complete combinationally in the issuing cycle.
- DIV/DIVU run on an iterative radix-2 restoring divider and hold the pipeline via stall_o until the result is written.
- Supports pipeline flush mid-division.

Parameters:
- DIV_ITERS, 32, number of quotient bits / iteration cycles (fixed to the data width).

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous reset, active-high
- start_i  in  1  EX instruction valid and targets HI/LO
- op_i  in  3  HI/LO op code (package constants)
- src_a_i  in  32  rs value (dividend / multiplicand / MT source)
- src_b_i  in  32  rt value (divisor / multiplier)
- hilo_cur_i  in  64  current HI/LO contents, {HI,LO}
- flush_i  in  1  cancel in-flight/issuing op
- stall_o  out  1  pipeline hold request
- hilo_we_o  out  1  write enable toward HI/LO register
- hilo_o  out  64  write data {HI,LO}

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: FSM=IDLE, counter=0, divider regs=0, stall_o=0, hilo_we_o=0, hilo_o=0. Reset mid-division aborts with no write.
- hilo_o is 0 whenever hilo_we_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i with MULT/MULTU/MTHI/MTLO, flush_i=0 (same cycle, combinational):
  - hilo_we_o=1; stall_o=0; FSM stays IDLE.
  - MULT: signed 32x32 -> 64.
  - MULTU: unsigned 32x32 -> 64.
  - MTHI: {src_a_i, hilo_cur_i[31:0]}.
  - MTLO: {hilo_cur_i[63:32], src_a_i}.
- IDLE, start_i with DIV/DIVU, flush_i=0 = cycle C0:
  - stall_o=1 (combinational).
  - Latch |a|, |b| (raw values for DIVU), the sign flags, and the div-by-zero flag.
  - counter=0; next state RUN.
- RUN (C1..C32):
  - One restoring step per cycle; stall_o=1.
  - counter increments; after the 32nd step -> DONE.
- DONE (C33):
  - hilo_we_o=1, hilo_o={remainder,quotient} from registers, stall_o=0.
  - Next state IDLE.
  - start_i in DONE is the same instruction being released and is ignored: no restart, no second write.
- Division totals: stall_o high 33 cycles (C0..C32); one write at C33.
- Signed fixup:
  - Quotient negated if sign(a)^sign(b).
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (wraps).
- Divide by zero, both DIV and DIVU: LO=0xFFFFFFFF, HI=src_a_i raw, no sign fixup; timing unchanged (34 cycles).
- flush_i has priority over everything except rst:
  - In IDLE it suppresses hilo_we_o and stall_o for the issuing op.
  - In RUN/DONE the next state is IDLE and no write occurs; in DONE, hilo_we_o is forced 0 that cycle.
  - stall_o is 0 in any cycle where flush_i=1.
- op_i outside the defined codes, or start_i=0: no write, no stall.
- Widths: dividend/remainder datapath 33 bits for the trial subtraction; product computed as full 64-bit with correct sign extension.

Decomposition:
- Shared header instrdefines.vh gains HI/LO op codes:
  - HILO_NOP=3'd0, HILO_MULT=3'd1, HILO_MULTU=3'd2, HILO_DIV=3'd3, HILO_DIVU=3'd4, HILO_MTHI=3'd5, HILO_MTLO=3'd6.
- FSM state encodings are local to the module.
- One natural sub-module: div_radix2.
  - Owns the RUN iterations, counter, sign/zero handling.
  - Ports: start, signed, a, b, flush, busy, done, q, r.
  - hilo_muldiv wraps it with the multiply/MT mux and the stall logic.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> same cycle hilo_we_o=1, hilo_o=0xFFFFFFFF_FFFFFFEB, stall_o=0; MULTU same operands -> 0x00000006_FFFFFFEB.
- DIVU 100/7 held under stall -> stall_o=1 for exactly 33 cycles, single hilo_we_o pulse at C33 with hilo_o={32'd2,32'd14}; start_i still high in DONE gives no restart.
- DIV -7/2 -> {HI,LO}={0xFFFFFFFF,0xFFFFFFFD}; DIV 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}.
- DIVU 0x12345678/0 and DIV 0x80000000/0 -> LO=0xFFFFFFFF, HI=dividend raw, 34-cycle timing.
- DIV started, flush_i pulsed at C10 -> no write ever, stall_o=0 from C10; DIVU 9/3 issued at C12 -> {0,3} written 33 cycles later. Same pattern with rst at C10 -> all outputs 0.
- MTHI src_a=0xAAAA5555, hilo_cur=0x11111111_22222222 -> hilo_o=0xAAAA5555_22222222; MTLO with flush_i=1 same cycle -> hilo_we_o=0.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: HI/LO op codes and divider sizing shared by hilo_muldiv, its interface, sub-module and bench
package hilo_muldiv_pkg;
  localparam int OP_W = 3;
  localparam int DIV_ITERS = 32;
  typedef enum logic [OP_W-1:0] {
    HILO_NOP   = 3'd0,
    HILO_MULT  = 3'd1,
    HILO_MULTU = 3'd2,
    HILO_DIV   = 3'd3,
    HILO_DIVU  = 3'd4,
    HILO_MTHI  = 3'd5,
    HILO_MTLO  = 3'd6
  } hilo_op_e;
endpackage

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: EX-stage HI/LO bus; master drives start_i/op_i/src_a_i/src_b_i/hilo_cur_i/flush_i, slave returns stall_o/hilo_we_o/hilo_o
interface hilo_muldiv_if;
  import hilo_muldiv_pkg::*;
  logic            start_i;
  logic [OP_W-1:0] op_i;
  logic [31:0]     src_a_i;
  logic [31:0]     src_b_i;
  logic [63:0]     hilo_cur_i;
  logic            flush_i;
  logic            stall_o;
  logic            hilo_we_o;
  logic [63:0]     hilo_o;
  modport master (output start_i, op_i, src_a_i, src_b_i, hilo_cur_i, flush_i, input stall_o, hilo_we_o, hilo_o);
  modport slave (input start_i, op_i, src_a_i, src_b_i, hilo_cur_i, flush_i, output stall_o, hilo_we_o, hilo_o);
endinterface

// File: rtl/hilo_muldiv_div_radix2.sv
// hilo_muldiv_div_radix2: radix-2 restoring divider FSM (IDLE/RUN/DONE); in clk/rst/start_i/signed_i/a_i/b_i/flush_i, out busy_o (RUN), done_o (DONE), q_o/r_o sign-fixed results
module hilo_muldiv_div_radix2 import hilo_muldiv_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] q_o,
  output logic [31:0] r_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int CW = $clog2(DIV_ITERS);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic          nq_q, nq_d, nr_q, nr_d, sa, sb, dz;
  logic [32:0]   sh, diff;
  always_comb begin
    sa = signed_i & a_i[31];
    sb = signed_i & b_i[31];
    dz = b_i == '0;
    sh = {rem_q, quo_q[31]};
    diff = sh - {1'b0, dvs_q};
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    nq_d = nq_q;
    nr_d = nr_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        cnt_d = '0;
        rem_d = '0;
        quo_d = (sa && !dz) ? -a_i : a_i;
        dvs_d = sb ? -b_i : b_i;
        nq_d = (sa ^ sb) & !dz;
        nr_d = sa & !dz;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        rem_d = diff[32] ? sh[31:0] : diff[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        state_d = (cnt_q == CW'(DIV_ITERS - 1)) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      nq_q <= nq_d;
      nr_q <= nr_d;
    end
  end
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
  assign q_o = nq_q ? -quo_q : quo_q;
  assign r_o = nr_q ? -rem_q : rem_q;
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: EX-stage HI/LO producer; clk/rst plain, bus slave modport (start/op/src_a/src_b/hilo_cur/flush in; stall/hilo_we/hilo out), single-cycle MULT/MULTU/MTHI/MTLO, 33-cycle-stall DIV/DIVU
module hilo_muldiv import hilo_muldiv_pkg::*; (
  input logic         clk,
  input logic         rst,
  hilo_muldiv_if.slave bus
);
  logic        is_div, is_imm, is_mult, idle, busy, done, issue, we;
  logic [31:0] q, r;
  logic [63:0] prod, imm_res;
  always_comb begin
    is_mult = bus.op_i == HILO_MULT;
    is_div = bus.op_i == HILO_DIV || bus.op_i == HILO_DIVU;
    is_imm = is_mult || bus.op_i == HILO_MULTU || bus.op_i == HILO_MTHI || bus.op_i == HILO_MTLO;
    idle = !busy && !done;
    issue = idle && bus.start_i && !bus.flush_i;
    prod = {{32{is_mult & bus.src_a_i[31]}}, bus.src_a_i} * {{32{is_mult & bus.src_b_i[31]}}, bus.src_b_i};
    imm_res = bus.op_i == HILO_MTHI ? {bus.src_a_i, bus.hilo_cur_i[31:0]} :
              bus.op_i == HILO_MTLO ? {bus.hilo_cur_i[63:32], bus.src_a_i} : prod;
    we = !bus.flush_i && ((issue && is_imm) || done);
    bus.hilo_we_o = we;
    bus.stall_o = !bus.flush_i && ((issue && is_div) || busy);
    bus.hilo_o = !we ? '0 : done ? {r, q} : imm_res;
  end
  hilo_muldiv_div_radix2 u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (issue && is_div),
    .signed_i (bus.op_i == HILO_DIV),
    .a_i      (bus.src_a_i),
    .b_i      (bus.src_b_i),
    .flush_i  (bus.flush_i),
    .busy_o   (busy),
    .done_o   (done),
    .q_o      (q),
    .r_o      (r)
  );
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: self-checking bench for hilo_muldiv with single-cycle vector table, division table and flush/reset sequences
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  hilo_muldiv_if bus();
  hilo_muldiv dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] cur;
    logic        we;
    logic        stall;
    logic [63:0] hilo;
  } vec_t;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
  } dvec_t;
  vec_t  v[13];
  dvec_t d[8];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic do_div(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int st = 0;
    int wr = 0;
    int wc = -1;
    int leak = 0;
    logic [63:0] got = '0;
    bus.op_i = op;
    bus.src_a_i = a;
    bus.src_b_i = b;
    bus.flush_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.start_i = (c <= 33);
      #1;
      if (bus.stall_o) st++;
      if (bus.hilo_we_o) begin
        wr++;
        wc = c;
        got = bus.hilo_o;
      end else if (bus.hilo_o != '0) leak++;
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b0;
    chk({name, "_stalls"}, 64'(st), 64'd33);
    chk({name, "_writes"}, 64'(wr), 64'd1);
    chk({name, "_wcycle"}, 64'(wc), 64'd33);
    chk({name, "_hilo"}, got, exp);
    chk({name, "_leak"}, 64'(leak), 64'd0);
  endtask
  initial begin
    int bad;
    v[0]  = '{1'b1, HILO_MULT,  1'b0, 32'hFFFFFFFD, 32'd7,        64'd0, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFEB};
    v[1]  = '{1'b1, HILO_MULTU, 1'b0, 32'hFFFFFFFD, 32'd7,        64'd0, 1'b1, 1'b0, 64'h00000006_FFFFFFEB};
    v[2]  = '{1'b1, HILO_MULT,  1'b0, 32'h80000000, 32'h80000000, 64'd0, 1'b1, 1'b0, 64'h40000000_00000000};
    v[3]  = '{1'b1, HILO_MULT,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b1, 1'b0, 64'h00000000_00000001};
    v[4]  = '{1'b1, HILO_MULTU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b1, 1'b0, 64'hFFFFFFFE_00000001};
    v[5]  = '{1'b1, HILO_MTHI,  1'b0, 32'hAAAA5555, 32'd0, 64'h11111111_22222222, 1'b1, 1'b0, 64'hAAAA5555_22222222};
    v[6]  = '{1'b1, HILO_MTLO,  1'b0, 32'h12345678, 32'd0, 64'h11111111_22222222, 1'b1, 1'b0, 64'h11111111_12345678};
    v[7]  = '{1'b1, HILO_MTLO,  1'b1, 32'h12345678, 32'd0, 64'h11111111_22222222, 1'b0, 1'b0, 64'd0};
    v[8]  = '{1'b1, 3'd7,       1'b0, 32'd5,        32'd6,        64'd0, 1'b0, 1'b0, 64'd0};
    v[9]  = '{1'b0, HILO_MULT,  1'b0, 32'd5,        32'd6,        64'd0, 1'b0, 1'b0, 64'd0};
    v[10] = '{1'b1, HILO_DIV,   1'b1, 32'd100,      32'd7,        64'd0, 1'b0, 1'b0, 64'd0};
    v[11] = '{1'b1, HILO_MULTU, 1'b0, 32'd3,        32'd5,        64'd0, 1'b1, 1'b0, 64'd15};
    v[12] = '{1'b1, HILO_MTHI,  1'b1, 32'hAAAA5555, 32'd0, 64'h11111111_22222222, 1'b0, 1'b0, 64'd0};
    d[0] = '{HILO_DIVU, 32'd100,      32'd7,        {32'd2, 32'd14}};
    d[1] = '{HILO_DIV,  32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
    d[2] = '{HILO_DIV,  32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
    d[3] = '{HILO_DIVU, 32'h12345678, 32'd0,        {32'h12345678, 32'hFFFFFFFF}};
    d[4] = '{HILO_DIV,  32'h80000000, 32'd0,        {32'h80000000, 32'hFFFFFFFF}};
    d[5] = '{HILO_DIV,  32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}};
    d[6] = '{HILO_DIV,  32'hFFFFFFF8, 32'hFFFFFFFD, {32'hFFFFFFFE, 32'd2}};
    d[7] = '{HILO_DIVU, 32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF}};
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i = HILO_NOP;
    bus.src_a_i = '0;
    bus.src_b_i = '0;
    bus.hilo_cur_i = '0;
    bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_we", 64'(bus.hilo_we_o), 64'd0);
    chk("rst_hilo", bus.hilo_o, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      bus.start_i = v[i].start;
      bus.op_i = v[i].op;
      bus.flush_i = v[i].flush;
      bus.src_a_i = v[i].a;
      bus.src_b_i = v[i].b;
      bus.hilo_cur_i = v[i].cur;
      #1;
      chk($sformatf("vec%0d_we", i), 64'(bus.hilo_we_o), 64'(v[i].we));
      chk($sformatf("vec%0d_stall", i), 64'(bus.stall_o), 64'(v[i].stall));
      chk($sformatf("vec%0d_hilo", i), bus.hilo_o, v[i].hilo);
    end
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) do_div($sformatf("div%0d", i), d[i].op, d[i].a, d[i].b, d[i].hilo);
    bus.op_i = HILO_DIV;
    bus.src_a_i = 32'd100;
    bus.src_b_i = 32'd7;
    for (int c = 0; c < 12; c++) begin
      bus.start_i = (c <= 10);
      bus.flush_i = (c == 10);
      #1;
      chk($sformatf("flush_c%0d_stall", c), 64'(bus.stall_o), 64'(c < 10));
      chk($sformatf("flush_c%0d_we", c), 64'(bus.hilo_we_o), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b0;
    do_div("after_flush", HILO_DIVU, 32'd9, 32'd3, {32'd0, 32'd3});
    bus.op_i = HILO_DIV;
    bus.src_a_i = 32'hFFFFFFF9;
    bus.src_b_i = 32'd2;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      bus.start_i = (c < 10);
      rst = (c == 10);
      #1;
      if (c == 5) chk("rst_seq_running", 64'(bus.stall_o), 64'd1);
      if (c == 11) begin
        chk("rst_seq_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_seq_we", 64'(bus.hilo_we_o), 64'd0);
        chk("rst_seq_hilo", bus.hilo_o, 64'd0);
      end
      if (c >= 11 && (bus.stall_o || bus.hilo_we_o || bus.hilo_o != '0)) bad++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    chk("rst_seq_quiet", 64'(bad), 64'd0);
    do_div("after_rst", HILO_DIVU, 32'd9, 32'd3, {32'd0, 32'd3});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
